// File: rtl/zx_hid_link_rx.sv
// HIDman MCU link receiver: syncs and deglitches the serial key lines and the
// parallel register strobes, then emits single-cycle CLK-domain write events.
module zx_hid_link_rx #(
    parameter int unsigned FILTER_LEN = 3,
    parameter int unsigned SETTLE     = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SK,
    input  logic       DAT,
    input  logic       STB,
    input  logic       MX,
    input  logic       MY,
    input  logic       MKEY,
    input  logic       JOY,
    input  logic [7:0] DI,
    output logic       key_we,
    output logic [3:0] key_ax,
    output logic [2:0] key_ay,
    output logic       key_state,
    output logic       reg_we,
    output logic [1:0] reg_sel,
    output logic [7:0] reg_data,
    output logic       frame_err
);

    localparam int NCH    = 6;
    localparam int CH_SK  = 0;
    localparam int CH_STB = 1;

    localparam logic [3:0] FLT_TOP   = 4'(FILTER_LEN - 1);
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_WRITE
    } state_t;

    logic [NCH-1:0] w_raw;
    logic [NCH-1:0] r_ch_s1;
    logic [NCH-1:0] r_ch_s2;
    logic           r_dat_s1;
    logic           r_dat_s2;
    logic [7:0]     r_di_s1;
    logic [7:0]     r_di_s2;

    logic [3:0]     r_flt_cnt [NCH];
    logic [NCH-1:0] r_flt;
    logic [NCH-1:0] r_flt_q;
    logic [NCH-1:0] w_rise;

    logic           w_sk_rise;
    logic           w_stb_rise;
    logic           w_stb_lvl;
    logic [6:0]     r_sr;
    logic [2:0]     r_cnt;
    logic           r_key_we;
    logic [3:0]     r_key_ax;
    logic [2:0]     r_key_ay;
    logic           r_key_state;
    logic           r_frame_err;

    logic [3:0]     w_reg_rise;
    logic [3:0]     r_pend;
    logic [3:0]     w_pick;
    logic [3:0]     w_clr;
    state_t         r_state;
    state_t         w_state_nxt;
    logic [3:0]     r_stl;
    logic [3:0]     w_stl_nxt;
    logic [1:0]     r_svc;
    logic [1:0]     w_svc_nxt;
    logic           w_cap;
    logic           r_reg_we;
    logic [1:0]     r_reg_sel;
    logic [7:0]     r_reg_data;

    assign w_raw = {JOY, MKEY, MY, MX, STB, SK};

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ch_s1  <= '0;
            r_ch_s2  <= '0;
            r_dat_s1 <= 1'b0;
            r_dat_s2 <= 1'b0;
            r_di_s1  <= '0;
            r_di_s2  <= '0;
        end else begin
            r_ch_s1  <= w_raw;
            r_ch_s2  <= r_ch_s1;
            r_dat_s1 <= DAT;
            r_dat_s2 <= r_dat_s1;
            r_di_s1  <= DI;
            r_di_s2  <= r_di_s1;
        end
    end

    // A level is accepted once it has been seen FILTER_LEN samples in a row.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_flt   <= '0;
            r_flt_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_flt_cnt[i] <= '0;
            end
        end else begin
            r_flt_q <= r_flt;
            for (int i = 0; i < NCH; i++) begin
                if (r_ch_s2[i] == r_flt[i]) begin
                    r_flt_cnt[i] <= '0;
                end else if (r_flt_cnt[i] == FLT_TOP) begin
                    r_flt[i]     <= r_ch_s2[i];
                    r_flt_cnt[i] <= '0;
                end else begin
                    r_flt_cnt[i] <= r_flt_cnt[i] + 4'd1;
                end
            end
        end
    end

    assign w_rise     = r_flt & ~r_flt_q;
    assign w_sk_rise  = w_rise[CH_SK];
    assign w_stb_rise = w_rise[CH_STB];
    assign w_stb_lvl  = r_flt[CH_STB];
    assign w_reg_rise = w_rise[5:2];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sr        <= '0;
            r_cnt       <= '0;
            r_key_we    <= 1'b0;
            r_key_ax    <= '0;
            r_key_ay    <= '0;
            r_key_state <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_key_we    <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_sk_rise) begin
                if (w_stb_lvl) begin
                    r_frame_err <= 1'b1;
                end else begin
                    r_sr <= {r_sr[5:0], r_dat_s2};
                    if (r_cnt != 3'd7) begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
            end
            // sr/cnt survive the strobe so a repeated STB re-applies the address.
            if (w_stb_rise) begin
                if (r_cnt == 3'd7) begin
                    r_key_we    <= 1'b1;
                    r_key_ax    <= r_sr[3:0];
                    r_key_ay    <= r_sr[6:4];
                    r_key_state <= r_dat_s2;
                end else begin
                    r_frame_err <= 1'b1;
                end
            end
        end
    end

    assign w_pick = r_pend & (~r_pend + 4'd1);

    always_comb begin
        w_state_nxt = r_state;
        w_stl_nxt   = r_stl;
        w_svc_nxt   = r_svc;
        w_clr       = '0;
        w_cap       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (|r_pend) begin
                    w_state_nxt = ST_SETTLE;
                    w_stl_nxt   = SETTLE_LD;
                    w_clr       = w_pick;
                    unique case (1'b1)
                        w_pick[0]: w_svc_nxt = 2'd0;
                        w_pick[1]: w_svc_nxt = 2'd1;
                        w_pick[2]: w_svc_nxt = 2'd2;
                        w_pick[3]: w_svc_nxt = 2'd3;
                        default:   w_svc_nxt = r_svc;
                    endcase
                end
            end
            ST_SETTLE: begin
                w_stl_nxt = r_stl - 4'd1;
                if (r_stl == 4'd1) begin
                    w_cap       = 1'b1;
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_stl      <= '0;
            r_svc      <= '0;
            r_pend     <= '0;
            r_reg_we   <= 1'b0;
            r_reg_sel  <= '0;
            r_reg_data <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_stl    <= w_stl_nxt;
            r_svc    <= w_svc_nxt;
            // A new rise of the strobe being served re-arms it.
            r_pend   <= (r_pend & ~w_clr) | w_reg_rise;
            r_reg_we <= w_cap;
            if (w_cap) begin
                r_reg_sel  <= r_svc;
                r_reg_data <= r_di_s2;
            end
        end
    end

    assign key_we    = r_key_we;
    assign key_ax    = r_key_ax;
    assign key_ay    = r_key_ay;
    assign key_state = r_key_state;
    assign frame_err = r_frame_err;
    assign reg_we    = r_reg_we;
    assign reg_sel   = r_reg_sel;
    assign reg_data  = r_reg_data;

endmodule

// File: tb/tb_zx_hid_link_rx.sv
// Directed bench for zx_hid_link_rx: pin-level stimulus, an event-schedule
// model of expected pulses and held outputs, checked on every falling edge.
module tb_zx_hid_link_rx;

    localparam int FL  = 3;
    localparam int ST  = 4;
    localparam int LAT = 2 + FL + 1;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       SK = 1'b0, DAT = 1'b0, STB = 1'b0;
    logic       MX = 1'b0, MY = 1'b0, MKEY = 1'b0, JOY = 1'b0;
    logic [7:0] DI = 8'h00;
    logic       key_we, key_state, reg_we, frame_err;
    logic [3:0] key_ax;
    logic [2:0] key_ay;
    logic [1:0] reg_sel;
    logic [7:0] reg_data;

    zx_hid_link_rx #(.FILTER_LEN(FL), .SETTLE(ST)) dut (
        .CLK(CLK), .RST(RST), .SK(SK), .DAT(DAT), .STB(STB),
        .MX(MX), .MY(MY), .MKEY(MKEY), .JOY(JOY), .DI(DI),
        .key_we(key_we), .key_ax(key_ax), .key_ay(key_ay),
        .key_state(key_state), .reg_we(reg_we), .reg_sel(reg_sel),
        .reg_data(reg_data), .frame_err(frame_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         due;
        logic [3:0] ax;
        logic [2:0] ay;
        logic       st;
    } kev_t;

    typedef struct {
        int         due;
        logic [1:0] sel;
        logic [7:0] d;
    } rev_t;

    int   cyc = 0;
    int   vectors = 0;
    int   errors = 0;
    logic chk_en = 1'b0;

    kev_t kq[$];
    rev_t rq[$];
    int   fq[$];
    bit   m_bits[$];
    int   m_next_start = 0;
    logic [3:0] m_ax;
    logic [2:0] m_ay;
    logic       m_st;
    logic [1:0] m_sel;
    logic [7:0] m_data;
    logic       e_k, e_r, e_f;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic model_zero();
        kq.delete();
        rq.delete();
        fq.delete();
        m_bits.delete();
        m_next_start = 0;
        m_ax = '0; m_ay = '0; m_st = 1'b0;
        m_sel = '0; m_data = '0;
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            e_k = (kq.size() > 0) && (kq[0].due == cyc);
            e_r = (rq.size() > 0) && (rq[0].due == cyc);
            e_f = (fq.size() > 0) && (fq[0] == cyc);
            if (e_k) begin
                m_ax = kq[0].ax; m_ay = kq[0].ay; m_st = kq[0].st;
                void'(kq.pop_front());
            end
            if (e_r) begin
                m_sel = rq[0].sel; m_data = rq[0].d;
                void'(rq.pop_front());
            end
            if (e_f) void'(fq.pop_front());
            chk("key_we", key_we, e_k);
            chk("key_ax", key_ax, m_ax);
            chk("key_ay", key_ay, m_ay);
            chk("key_state", key_state, m_st);
            chk("reg_we", reg_we, e_r);
            chk("reg_sel", reg_sel, m_sel);
            chk("reg_data", reg_data, m_data);
            chk("frame_err", frame_err, e_f);
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_key_ax0"}, key_ax, 0);
        chk({tag, "_key_ay0"}, key_ay, 0);
        chk({tag, "_key_st0"}, key_state, 0);
        chk({tag, "_reg_sel0"}, reg_sel, 0);
        chk({tag, "_reg_data0"}, reg_data, 0);
        chk({tag, "_pulses0"}, {key_we, reg_we, frame_err}, 0);
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        RST = 1'b1;
        model_zero();
        tick(3);
        RST = 1'b0;
        tick(2);
        chk_en = 1'b1;
    endtask

    task automatic sk_bit(input bit d);
        DAT = d;
        tick(2);
        SK = 1'b1;
        m_bits.push_back(d);
        tick(6);
        SK = 1'b0;
        tick(6);
    endtask

    // Expected key event from the last seven shifted bits, first bit = MSB of Y.
    task automatic expect_key(input int due, input logic d);
        int n, ay, ax;
        n  = m_bits.size();
        ay = int'(m_bits[n-7]) * 4 + int'(m_bits[n-6]) * 2 + int'(m_bits[n-5]);
        ax = int'(m_bits[n-4]) * 8 + int'(m_bits[n-3]) * 4
           + int'(m_bits[n-2]) * 2 + int'(m_bits[n-1]);
        kq.push_back('{due, 4'(ax), 3'(ay), d});
    endtask

    task automatic stb_pulse(input logic d, input bit sk_inside);
        DAT = d;
        tick(2);
        STB = 1'b1;
        if (m_bits.size() >= 7) expect_key(cyc + LAT, d);
        else fq.push_back(cyc + LAT);
        tick(8);
        if (sk_inside) begin
            SK = 1'b1;
            fq.push_back(cyc + LAT);
            tick(6);
            SK = 1'b0;
            tick(4);
        end
        STB = 1'b0;
        tick(8);
    endtask

    // Writes are served lowest index first, SETTLE after selection, with
    // two idle cycles between the end of one write and the next selection.
    task automatic sched(input logic [3:0] mask, input logic [7:0] d,
                         input int n);
        int p, s, w;
        p = n + LAT;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                s = (p + 1 > m_next_start) ? p + 1 : m_next_start;
                w = s + ST;
                rq.push_back('{w, 2'(i), d});
                m_next_start = w + 2;
            end
        end
    endtask

    task automatic strobes(input logic [3:0] mask, input logic [7:0] d);
        DI = d;
        tick(2);
        {JOY, MKEY, MY, MX} = mask;
        sched(mask, d, cyc);
        tick(8);
        {JOY, MKEY, MY, MX} = 4'b0000;
        tick(8);
    endtask

    initial begin
        int n0, lat;
        model_zero();
        tick(1);
        do_reset();
        check_zero("rst");

        // Y2,X4 then a bare strobe re-applies with the new state
        sk_bit(0); sk_bit(1); sk_bit(0); sk_bit(0);
        sk_bit(1); sk_bit(0); sk_bit(0);
        stb_pulse(1'b1, 1'b0);
        chk("t1_ax", key_ax, 4);
        chk("t1_ay", key_ay, 2);
        chk("t1_st", key_state, 1);
        stb_pulse(1'b0, 1'b0);
        chk("t1_st_off", key_state, 0);

        // short frame, then nine bits keeping the last seven
        do_reset();
        check_zero("rst2");
        sk_bit(1); sk_bit(1); sk_bit(1); sk_bit(0); sk_bit(0);
        stb_pulse(1'b1, 1'b0);
        sk_bit(0); sk_bit(1); sk_bit(0); sk_bit(1);
        stb_pulse(1'b1, 1'b0);
        chk("t2_ax", key_ax, 5);
        chk("t2_ay", key_ay, 4);
        stb_pulse(1'b1, 1'b1);

        // single MX load and its pin-to-pulse latency
        DI = 8'h80;
        tick(2);
        MX = 1'b1;
        n0 = cyc;
        sched(4'b0001, 8'h80, n0);
        lat = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (reg_we === 1'b1) begin
                lat = cyc - n0;
                break;
            end
        end
        chk("t3_latency", lat, 11);
        chk("t3_data", reg_data, 8'h80);
        chk("t3_sel", reg_sel, 0);
        @(posedge CLK);
        #1;
        MX = 1'b0;
        tick(8);

        // simultaneous MX, MY, JOY
        strobes(4'b1011, 8'h3C);
        tick(30);
        chk("t4_sel_last", reg_sel, 3);
        chk("t4_data", reg_data, 8'h3C);

        // two-cycle glitches must not shift or load
        SK = 1'b1; MKEY = 1'b1;
        tick(2);
        SK = 1'b0; MKEY = 1'b0;
        tick(20);
        stb_pulse(1'b0, 1'b0);
        chk("t5_ax", key_ax, 5);
        chk("t5_ay", key_ay, 4);
        chk("t5_sel", reg_sel, 3);

        // reset while settling with two strobes still pending
        DI = 8'h5A;
        tick(2);
        {MKEY, MY, MX} = 3'b111;
        sched(4'b0111, 8'h5A, cyc);
        tick(6);
        {MKEY, MY, MX} = 3'b000;
        tick(2);
        do_reset();
        check_zero("t6");
        tick(40);

        chk("end_kq_empty", kq.size(), 0);
        chk("end_rq_empty", rq.size(), 0);
        chk("end_fq_empty", fq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
